ahb_bus_arbiter: RTL and testbench

//  Shares the single AHB slave port of the AHB2APB bridge between NUM_MASTERS requesting masters.

---
 rtl/ahb_bridge_pkg.sv | 32 +++
 rtl/ahb_bus_arbiter_picker.sv | 40 ++++
 rtl/ahb_bus_arbiter.sv | 109 ++++++++++
 tb/tb_ahb_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bridge_pkg.sv
// Shared definitions for the AHB2APB bridge: HTRANS/HRESP encodings and arbiter states.
package ahb_bridge_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    ARB_PARK,
    ARB_OWNED,
    ARB_LOCKED,
    ARB_LOCK_END
  } arb_state_e;

  localparam int HOLD_CNT_W = 8;

  // Ownership may only move when no burst is in flight: a completed IDLE or a fresh NONSEQ.
  function automatic logic is_arb_point(input logic [1:0] htrans, input logic hready);
    return hready && ((htrans_e'(htrans) == HTRANS_IDLE) || (htrans_e'(htrans) == HTRANS_NONSEQ));
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_picker.sv
// Combinational round-robin picker: first unmasked requester scanning upward from rr_ptr+1.
module rr_priority_picker
  import ahb_bridge_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int MASTER_W    = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] mask,
  input  logic [MASTER_W-1:0]    rr_ptr,
  output logic [NUM_MASTERS-1:0] winner_onehot,
  output logic [MASTER_W-1:0]    winner_idx,
  output logic                   winner_valid
);

  logic [MASTER_W:0]   sum;
  logic [MASTER_W-1:0] idx;

  // Scan farthest-first so the nearest requester after rr_ptr is the last to overwrite.
  always_comb begin
    winner_onehot = '0;
    winner_idx    = '0;
    winner_valid  = 1'b0;
    sum           = '0;
    idx           = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      sum = {1'b0, rr_ptr} + (MASTER_W+1)'(k);
      if (sum >= (MASTER_W+1)'(NUM_MASTERS))
        sum = sum - (MASTER_W+1)'(NUM_MASTERS);
      idx = sum[MASTER_W-1:0];
      if (req[idx] && !mask[idx]) begin
        winner_onehot      = '0;
        winner_onehot[idx] = 1'b1;
        winner_idx         = idx;
        winner_valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter with hold-limit fairness, locked sequences and a parked default master.
module ahb_bus_arbiter
  import ahb_bridge_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int MASTER_W       = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 8
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MASTER_W-1:0]    HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MASTER_W-1:0]    DEFAULT_IDX   = MASTER_W'(DEFAULT_MASTER);
  localparam logic [HOLD_CNT_W-1:0]  HOLD_MAX      = HOLD_CNT_W'(MAX_HOLD);

  arb_state_e            state;
  logic [MASTER_W-1:0]   owner_idx;
  logic [MASTER_W-1:0]   rr_ptr;
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic [HOLD_CNT_W-1:0] hold_inc;

  logic                   arb_ok;
  logic                   owner_req;
  logic                   owner_lock;
  logic                   others_req;
  logic                   beat;
  logic                   keep;
  logic                   take;
  logic                   go_park;
  logic [NUM_MASTERS-1:0] pick_mask;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [MASTER_W-1:0]    pick_idx;
  logic                   pick_valid;

  // The current owner is never a handover candidate; in PARK everyone, including the default, may win.
  assign pick_mask = (state == ARB_PARK) ? '0 : HGRANT;

  rr_priority_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .MASTER_W   (MASTER_W)
  ) u_picker (
    .req          (HBUSREQ),
    .mask         (pick_mask),
    .rr_ptr       (rr_ptr),
    .winner_onehot(pick_onehot),
    .winner_idx   (pick_idx),
    .winner_valid (pick_valid)
  );

  // Beats only count while the grant holder actually owns the address phase.
  always_comb begin
    arb_ok     = is_arb_point(HTRANS, HREADY);
    owner_req  = HBUSREQ[owner_idx];
    owner_lock = owner_req && HLOCK[owner_idx];
    others_req = |(HBUSREQ & ~HGRANT);
    beat       = HREADY && HTRANS[1] && (HMASTER == owner_idx);
    hold_inc   = (beat && (hold_cnt < HOLD_MAX)) ? hold_cnt + 1'b1 : hold_cnt;
    keep       = owner_req && (!others_req || (hold_cnt < HOLD_MAX));
    take       = arb_ok && pick_valid &&
                 ((state == ARB_PARK) || ((state == ARB_OWNED) && !keep));
    go_park    = arb_ok && !pick_valid && (state == ARB_OWNED) && !keep;
  end

  // Address-phase owner follows the grant one HREADY cycle later; HREADY low freezes everything.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= ARB_PARK;
      HGRANT    <= DEFAULT_GRANT;
      owner_idx <= DEFAULT_IDX;
      rr_ptr    <= DEFAULT_IDX;
      hold_cnt  <= '0;
      HMASTER   <= DEFAULT_IDX;
      HMASTLOCK <= 1'b0;
    end else if (HREADY) begin
      HMASTER   <= owner_idx;
      HMASTLOCK <= (state == ARB_LOCKED) || (state == ARB_LOCK_END);
      hold_cnt  <= hold_inc;
      if (take) begin
        HGRANT    <= pick_onehot;
        owner_idx <= pick_idx;
        rr_ptr    <= pick_idx;
        hold_cnt  <= '0;
        state     <= HLOCK[pick_idx] ? ARB_LOCKED : ARB_OWNED;
      end else if (go_park) begin
        HGRANT    <= DEFAULT_GRANT;
        owner_idx <= DEFAULT_IDX;
        hold_cnt  <= '0;
        state     <= ARB_PARK;
      end else if (arb_ok) begin
        unique case (state)
          ARB_PARK:     state <= ARB_PARK;
          ARB_OWNED:    state <= owner_lock ? ARB_LOCKED : ARB_OWNED;
          ARB_LOCKED:   state <= owner_lock ? ARB_LOCKED : ARB_LOCK_END;
          ARB_LOCK_END: state <= ARB_OWNED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: vector table, directed corner sequences, random vs model.
module tb_ahb_bus_arbiter;

  localparam int N        = 3;
  localparam int MAX_HOLD = 8;
  localparam int DEF_M    = 0;

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic [N-1:0] HBUSREQ;
  logic [N-1:0] HLOCK;
  logic [1:0]   HTRANS;
  logic         HREADY;
  logic [N-1:0] HGRANT;
  logic [1:0]   HMASTER;
  logic         HMASTLOCK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integers describing who owns the bus and what phase of lock we are in.
  int m_owner, m_ptr, m_hold, m_lock_phase, m_master;
  bit m_parked, m_mastlock;

  typedef struct {
    logic [2:0] req;
    logic [2:0] lock;
    logic [1:0] trans;
    logic       ready;
    logic [2:0] grant;
    logic [1:0] master;
    logic       mastlock;
  } vec_t;

  vec_t vecs[17];

  ahb_bus_arbiter #(
    .NUM_MASTERS(N),
    .MASTER_W(2),
    .DEFAULT_MASTER(DEF_M),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .HBUSREQ  (HBUSREQ),
    .HLOCK    (HLOCK),
    .HTRANS   (HTRANS),
    .HREADY   (HREADY),
    .HGRANT   (HGRANT),
    .HMASTER  (HMASTER),
    .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  task automatic model_reset();
    m_owner = DEF_M; m_ptr = DEF_M; m_hold = 0; m_lock_phase = 0;
    m_master = DEF_M; m_parked = 1; m_mastlock = 0;
  endtask

  function automatic int rr_next(input logic [2:0] req);
    int found = -1;
    for (int k = 1; k <= N; k++) begin
      int i = (m_ptr + k) % N;
      if (found < 0 && req[i]) found = i;
    end
    return found;
  endfunction

  task automatic model_step(input logic [2:0] req, input logic [2:0] lock,
                            input logic [1:0] trans, input logic ready);
    int old_owner, w;
    bit old_lock, beat, arb, changed;
    logic [2:0] others;
    if (!ready) return;
    old_owner = m_owner;
    old_lock  = (m_lock_phase != 0);
    beat      = trans[1] && (m_master == m_owner);
    arb       = (trans == 2'b00) || (trans == 2'b10);
    changed   = 0;
    w         = -1;
    if (arb) begin
      others = req;
      others[m_owner] = 1'b0;
      if (m_parked) begin
        w = rr_next(req);
      end else if (m_lock_phase == 2) begin
        if (!(req[m_owner] && lock[m_owner])) m_lock_phase = 1;
      end else if (m_lock_phase == 1) begin
        m_lock_phase = 0;
      end else if (req[m_owner] && (others == 0 || m_hold < MAX_HOLD)) begin
        if (lock[m_owner]) m_lock_phase = 2;
      end else if (others != 0) begin
        w = rr_next(others);
      end else begin
        m_parked = 1; m_owner = DEF_M; changed = 1;
      end
      if (w >= 0) begin
        m_owner = w; m_ptr = w; m_parked = 0; changed = 1;
        m_lock_phase = lock[w] ? 2 : 0;
      end
    end
    if (changed) m_hold = 0;
    else if (beat && m_hold < MAX_HOLD) m_hold++;
    m_master   = old_owner;
    m_mastlock = old_lock;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output(input string name, input logic [2:0] g, input logic [1:0] m, input logic l);
    check_val({name, ".grant"},    32'(HGRANT),    32'(g));
    check_val({name, ".master"},   32'(HMASTER),   32'(m));
    check_val({name, ".mastlock"}, 32'(HMASTLOCK), 32'(l));
  endtask

  task automatic check_model(input string name);
    check_output(name, 3'(1 << m_owner), 2'(m_master), m_mastlock);
  endtask

  // Drive at the falling edge, let the model see the same inputs at the rising edge, return at falling.
  task automatic apply_stimulus(input logic [2:0] req, input logic [2:0] lock,
                                input logic [1:0] trans, input logic ready);
    HBUSREQ = req; HLOCK = lock; HTRANS = trans; HREADY = ready;
    @(posedge HCLK);
    model_step(req, lock, trans, ready);
    @(negedge HCLK);
  endtask

  task automatic do_reset();
    HBUSREQ = '0; HLOCK = '0; HTRANS = 2'b00; HREADY = 1'b1;
    HRESET = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [2:0] rq, lk;

    vecs[0]  = '{3'b000, 3'b000, 2'b00, 1'b1, 3'b001, 2'd0, 1'b0};
    vecs[1]  = '{3'b110, 3'b000, 2'b00, 1'b1, 3'b010, 2'd0, 1'b0};
    vecs[2]  = '{3'b110, 3'b000, 2'b00, 1'b1, 3'b010, 2'd1, 1'b0};
    vecs[3]  = '{3'b100, 3'b000, 2'b00, 1'b1, 3'b100, 2'd1, 1'b0};
    vecs[4]  = '{3'b100, 3'b000, 2'b00, 1'b1, 3'b100, 2'd2, 1'b0};
    vecs[5]  = '{3'b000, 3'b000, 2'b00, 1'b1, 3'b001, 2'd2, 1'b0};
    vecs[6]  = '{3'b000, 3'b000, 2'b00, 1'b1, 3'b001, 2'd0, 1'b0};
    vecs[7]  = '{3'b010, 3'b000, 2'b00, 1'b1, 3'b010, 2'd0, 1'b0};
    vecs[8]  = '{3'b010, 3'b000, 2'b00, 1'b0, 3'b010, 2'd0, 1'b0};
    vecs[9]  = '{3'b010, 3'b000, 2'b00, 1'b0, 3'b010, 2'd0, 1'b0};
    vecs[10] = '{3'b010, 3'b000, 2'b00, 1'b0, 3'b010, 2'd0, 1'b0};
    vecs[11] = '{3'b010, 3'b000, 2'b00, 1'b0, 3'b010, 2'd0, 1'b0};
    vecs[12] = '{3'b010, 3'b000, 2'b00, 1'b0, 3'b010, 2'd0, 1'b0};
    vecs[13] = '{3'b010, 3'b000, 2'b00, 1'b1, 3'b010, 2'd1, 1'b0};
    vecs[14] = '{3'b000, 3'b000, 2'b00, 1'b0, 3'b010, 2'd1, 1'b0};
    vecs[15] = '{3'b000, 3'b000, 2'b00, 1'b1, 3'b001, 2'd1, 1'b0};
    vecs[16] = '{3'b000, 3'b000, 2'b00, 1'b1, 3'b001, 2'd0, 1'b0};

    do_reset();
    check_output("reset", 3'b001, 2'd0, 1'b0);

    // Idle bus stays parked on the default master.
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(3'b000, 3'b000, 2'b00, 1'b1);
      check_output("park_idle", 3'b001, 2'd0, 1'b0);
    end

    // Round-robin handover, parking, and HREADY wait states across a handover.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(vecs[i].req, vecs[i].lock, vecs[i].trans, vecs[i].ready);
      check_output($sformatf("vec%0d", i), vecs[i].grant, vecs[i].master, vecs[i].mastlock);
    end

    // Hold limit: M0 bursts while M2 waits; handover only at the NONSEQ after the 8th beat.
    do_reset();
    apply_stimulus(3'b001, 3'b000, 2'b00, 1'b1);
    check_output("hold_own", 3'b001, 2'd0, 1'b0);
    apply_stimulus(3'b101, 3'b000, 2'b10, 1'b1);
    check_output("hold_b1", 3'b001, 2'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(3'b101, 3'b000, 2'b11, 1'b1);
      check_output("hold_seq", 3'b001, 2'd0, 1'b0);
    end
    apply_stimulus(3'b101, 3'b000, 2'b10, 1'b1);
    check_output("hold_move", 3'b100, 2'd0, 1'b0);
    apply_stimulus(3'b101, 3'b000, 2'b10, 1'b1);
    check_model("hold_after");

    // Locked sequence ignores competing requests, then one LOCK_END beat before handover.
    do_reset();
    apply_stimulus(3'b010, 3'b010, 2'b00, 1'b1);
    check_output("lock_grant", 3'b010, 2'd0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      apply_stimulus(3'b111, 3'b010, 2'b10, 1'b1);
      check_output("lock_hold", 3'b010, 2'd1, 1'b1);
    end
    apply_stimulus(3'b101, 3'b000, 2'b00, 1'b1);
    check_output("lock_fall", 3'b010, 2'd1, 1'b1);
    apply_stimulus(3'b101, 3'b000, 2'b00, 1'b1);
    check_output("lock_end", 3'b010, 2'd1, 1'b1);
    apply_stimulus(3'b101, 3'b000, 2'b00, 1'b1);
    check_output("lock_next", 3'b100, 2'd1, 1'b0);
    apply_stimulus(3'b101, 3'b000, 2'b00, 1'b1);
    check_output("lock_after", 3'b100, 2'd2, 1'b0);

    // Asynchronous reset in the middle of an M2 burst.
    do_reset();
    apply_stimulus(3'b100, 3'b000, 2'b00, 1'b1);
    apply_stimulus(3'b100, 3'b000, 2'b10, 1'b1);
    apply_stimulus(3'b100, 3'b000, 2'b11, 1'b1);
    check_output("burst_m2", 3'b100, 2'd2, 1'b0);
    HTRANS = 2'b11;
    #2 HRESET = 1'b1;
    #1 check_output("async_rst", 3'b001, 2'd0, 1'b0);
    @(negedge HCLK);
    HRESET = 1'b0;
    model_reset();
    HBUSREQ = '0; HTRANS = 2'b00;

    // Randomised traffic against the reference model.
    rq = '0;
    lk = '0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) rq[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) lk = 3'($urandom_range(0, 7));
      apply_stimulus(rq, lk, 2'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0));
      check_model("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
